load_store_unit: RTL and testbench

//   Memory-access stage downstream of the ALU/execute stage of the RV32I core. Serves LB/LH/LW/LBU/LHU/SB/SH/SW:
//   - computes the effective address rs1+imm;
//   - drives a word-addressed data-memory request/acknowledge bus with byte-lane write masks;
//   - returns aligned, sign/zero-extended load data for register write-back.
//   The core's FSM holds in its execute state while busy=1 and retires the instruction on done.

---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: computes rs1+imm, runs a single request/acknowledge
// data-memory transaction with byte-lane masks, and formats load results.
module load_store_unit #(
  parameter int MEM_AW  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       base,
  input  logic [31:0]       imm,
  input  logic [31:0]       store_data,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              err_misalign,
  output logic              err_fault
);

  localparam int AW = MEM_AW + 2;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [AW-1:0] eff_addr_q, eff_addr_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] sdata_q, sdata_d;
  logic [15:0] cnt_q, cnt_d;

  logic              mem_req_d, busy_d, done_d, err_mis_d, err_flt_d;
  logic [MEM_AW-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d, load_data_d;
  logic [3:0]        mem_wmask_d;

  logic        legal, misaligned;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data, fmt_data;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Legality and alignment of the captured access; funct3[1:0] encodes size.
  always_comb begin
    legal      = is_store_q ? (funct3_q inside {3'b000, 3'b001, 3'b010})
                            : (funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((funct3_q[1:0] == 2'b01) && eff_addr_q[0]) ||
                 ((funct3_q[1:0] == 2'b10) && (eff_addr_q[1:0] != 2'b00));
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case statements can leave it unassigned and infer a latch.
    lane_mask = 4'b1111;
    lane_data = sdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << eff_addr_q[1:0];
        lane_data = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask = eff_addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{sdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rbyte = mem_rdata[7:0];
    case (eff_addr_q[1:0])
      2'b01:   rbyte = mem_rdata[15:8];
      2'b10:   rbyte = mem_rdata[23:16];
      2'b11:   rbyte = mem_rdata[31:24];
      default: ;
    endcase
    rhalf = eff_addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  fmt_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  fmt_data = {{16{rhalf[15]}}, rhalf};
      3'b100:  fmt_data = {24'h0, rbyte};
      3'b101:  fmt_data = {16'h0, rhalf};
      default: fmt_data = mem_rdata;
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    eff_addr_d  = eff_addr_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    sdata_d     = sdata_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wmask_d = mem_wmask;
    done_d      = 1'b0;
    load_data_d = 32'h0;
    err_mis_d   = 1'b0;
    err_flt_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CHECK;
          eff_addr_d = AW'(base + imm);
          is_store_d = is_store;
          funct3_d   = funct3;
          sdata_d    = store_data;
        end
      end
      S_CHECK: begin
        if (!legal) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          err_flt_d = 1'b1;
        end else if (misaligned) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          err_mis_d = 1'b1;
        end else begin
          state_d     = S_REQ;
          cnt_d       = 16'h0;
          mem_req_d   = 1'b1;
          mem_addr_d  = eff_addr_q[AW-1:2];
          mem_wdata_d = is_store_q ? lane_data : 32'h0;
          mem_wmask_d = is_store_q ? lane_mask : 4'b0000;
        end
      end
      S_REQ: begin
        if (mem_ack || (cnt_q == 16'(TIMEOUT - 1))) begin
          // An acknowledge in the final allowed cycle still completes the access.
          state_d     = S_DONE;
          done_d      = 1'b1;
          err_flt_d   = !mem_ack;
          load_data_d = (mem_ack && !is_store_q) ? fmt_data : 32'h0;
          mem_req_d   = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = 32'h0;
          mem_wmask_d = 4'b0000;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (!RESETN) begin
      state_q      <= S_IDLE;
      eff_addr_q   <= '0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      sdata_q      <= 32'h0;
      cnt_q        <= 16'h0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'h0;
      mem_wmask    <= 4'b0000;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_data    <= 32'h0;
      err_misalign <= 1'b0;
      err_fault    <= 1'b0;
    end else begin
      state_q      <= state_d;
      eff_addr_q   <= eff_addr_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      sdata_q      <= sdata_d;
      cnt_q        <= cnt_d;
      mem_req      <= mem_req_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      mem_wmask    <= mem_wmask_d;
      busy         <= busy_d;
      done         <= done_d;
      load_data    <= load_data_d;
      err_misalign <= err_mis_d;
      err_fault    <= err_flt_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected requests and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_load_store_unit;

  localparam int MEM_AW  = 8;
  localparam int TIMEOUT = 4;

  logic              CLK = 1'b0;
  logic              RESETN = 1'b0;
  logic              start = 1'b0;
  logic              is_store = 1'b0;
  logic [2:0]        funct3 = 3'b000;
  logic [31:0]       base = 32'h0;
  logic [31:0]       imm = 32'h0;
  logic [31:0]       store_data = 32'h0;
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = 32'h0;
  logic              busy;
  logic              done;
  logic [31:0]       load_data;
  logic              err_misalign;
  logic              err_fault;

  load_store_unit #(.MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESETN(RESETN), .start(start), .is_store(is_store),
    .funct3(funct3), .base(base), .imm(imm), .store_data(store_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .load_data(load_data),
    .err_misalign(err_misalign), .err_fault(err_fault)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        flt;
    int          at;
    int          req_cycles;
  } done_exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        is_st;
    int          at;
  } req_exp_t;

  done_exp_t done_q[$];
  req_exp_t  req_q[$];

  // Memory responder: acks after ack_delay waiting cycles of mem_req.
  int          ack_delay = 0;
  bit          ack_never = 1'b0;
  logic [31:0] rdata_val = 32'h0;
  int          wait_cnt = 0;

  always @(negedge CLK) begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    if (mem_req && !ack_never) begin
      if (wait_cnt == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_val;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Monitor
  bit req_active = 1'b0;
  int req_cnt = 0;

  always @(negedge CLK) begin : monitor
    req_exp_t  r;
    done_exp_t d;
    if (!busy) req_cnt = 0;
    if (mem_req) begin
      req_cnt++;
      if (!req_active) begin
        req_active = 1'b1;
        if (req_q.size() == 0) begin
          check("unexpected_req", 1, 0);
        end else begin
          r = req_q.pop_front();
          check("req_addr", mem_addr, r.addr);
          check("req_wmask", mem_wmask, r.wmask);
          if (r.is_st) check("req_wdata", mem_wdata, r.wdata);
          check("req_cycle", cyc, r.at);
        end
      end
    end else begin
      req_active = 1'b0;
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        d = done_q.pop_front();
        check("load_data", load_data, d.data);
        check("err_misalign", err_misalign, d.mis);
        check("err_fault", err_fault, d.flt);
        check("done_cycle", cyc, d.at);
        check("req_cycles", req_cnt, d.req_cycles);
      end
    end else begin
      check("load_data_idle", load_data, 0);
    end
  end

  // Called at posedge+#1 while the DUT is idle.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] i, input logic [31:0] sd, input logic [31:0] rd,
                       input int k, input bit never, input bit hold, input bit has_req,
                       input logic [7:0] eaddr, input logic [3:0] emask, input logic [31:0] ewdata,
                       input logic [31:0] edata, input bit emis, input bit eflt,
                       input int lat, input int ereq);
    int n;
    ack_delay = k;
    ack_never = never;
    rdata_val = rd;
    if (has_req) req_q.push_back('{eaddr, emask, ewdata, st, cyc + 2});
    done_q.push_back('{edata, emis, eflt, cyc + lat, ereq});
    start = 1'b1; is_store = st; funct3 = f3; base = b; imm = i; store_data = sd;
    @(posedge CLK); #1;
    start = hold; funct3 = 3'b111; base = 32'hFFFF_FFFF; imm = 32'h0000_0001; store_data = 32'h0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    check("done_seen", done, 1);
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_wmask", mem_wmask, 0);
    check("rst_load_data", load_data, 0);
    check("rst_errs", {err_misalign, err_fault}, 0);
    RESETN = 1'b1;
    @(posedge CLK); #1;

    //    st f3      base          imm           sd            rdata         k  nv hd rq addr  mask    wdata         data          mis flt lat req
    issue(0, 3'b010, 32'h10,       32'h4,        32'h0,        32'hDEADBEEF, 0, 0, 0, 1, 8'h05, 4'h0, 32'h0,        32'hDEADBEEF, 0, 0, 3, 1); // LW
    issue(0, 3'b000, 32'h10,       32'h3,        32'h0,        32'h80112233, 0, 0, 0, 1, 8'h04, 4'h0, 32'h0,        32'hFFFFFF80, 0, 0, 3, 1); // LB
    issue(0, 3'b100, 32'h10,       32'h3,        32'h0,        32'h80112233, 0, 0, 0, 1, 8'h04, 4'h0, 32'h0,        32'h00000080, 0, 0, 3, 1); // LBU
    issue(0, 3'b101, 32'h10,       32'h2,        32'h0,        32'h80112233, 0, 0, 0, 1, 8'h04, 4'h0, 32'h0,        32'h00008011, 0, 0, 3, 1); // LHU
    issue(0, 3'b001, 32'h20,       32'hFFFFFFF0, 32'h0,        32'h0000F00D, 1, 0, 0, 1, 8'h04, 4'h0, 32'h0,        32'hFFFFF00D, 0, 0, 4, 2); // LH, wrap add
    issue(1, 3'b000, 32'h20,       32'h1,        32'h000000A5, 32'hFFFFFFFF, 0, 0, 0, 1, 8'h08, 4'h2, 32'hA5A5A5A5, 32'h0,        0, 0, 3, 1); // SB
    issue(1, 3'b001, 32'h20,       32'h2,        32'h00001234, 32'hFFFFFFFF, 2, 0, 0, 1, 8'h08, 4'hC, 32'h12341234, 32'h0,        0, 0, 5, 3); // SH
    issue(1, 3'b010, 32'h100,      32'h3FC,      32'hCAFEF00D, 32'hFFFFFFFF, 0, 0, 0, 1, 8'h3F, 4'hF, 32'hCAFEF00D, 32'h0,        0, 0, 3, 1); // SW, high bits dropped
    issue(0, 3'b010, 32'h0,        32'h2,        32'h0,        32'h0,        0, 0, 0, 0, 8'h00, 4'h0, 32'h0,        32'h0,        1, 0, 2, 0); // LW misaligned
    issue(0, 3'b001, 32'h11,       32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 8'h00, 4'h0, 32'h0,        32'h0,        1, 0, 2, 0); // LH misaligned
    issue(1, 3'b001, 32'h21,       32'h0,        32'h1234,     32'h0,        0, 0, 0, 0, 8'h00, 4'h0, 32'h0,        32'h0,        1, 0, 2, 0); // SH misaligned
    issue(0, 3'b011, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 8'h00, 4'h0, 32'h0,        32'h0,        0, 1, 2, 0); // illegal load
    issue(0, 3'b011, 32'h3,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 8'h00, 4'h0, 32'h0,        32'h0,        0, 1, 2, 0); // illegal beats misalign
    issue(1, 3'b100, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 8'h00, 4'h0, 32'h0,        32'h0,        0, 1, 2, 0); // illegal store
    issue(0, 3'b010, 32'h40,       32'h0,        32'h0,        32'h0,        0, 1, 0, 1, 8'h10, 4'h0, 32'h0,        32'h0,        0, 1, 6, 4); // timeout
    issue(0, 3'b010, 32'h44,       32'h0,        32'h0,        32'h11223344, 3, 0, 1, 1, 8'h11, 4'h0, 32'h0,        32'h11223344, 0, 0, 6, 4); // ack on last cycle, start held

    // Reset during REQ: request drops, no completion.
    ack_never = 1'b1;
    req_q.push_back('{8'h18, 4'h0, 32'h0, 1'b0, cyc + 2});
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; base = 32'h60; imm = 32'h0;
    @(posedge CLK); #1;
    start = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(posedge CLK); #1;
      n++;
    end
    check("req_before_reset", mem_req, 1);
    @(posedge CLK); #1;
    RESETN = 1'b0;
    @(posedge CLK); #1;
    check("reset_mem_req", mem_req, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    RESETN = 1'b1;
    ack_never = 1'b0;
    repeat (6) @(posedge CLK);
    #1;

    issue(0, 3'b010, 32'h80, 32'h0, 32'h0, 32'h0BADF00D, 0, 0, 0, 1, 8'h20, 4'h0, 32'h0, 32'h0BADF00D, 0, 0, 3, 1); // recovery

    repeat (5) @(posedge CLK);
    #1;
    check("done_q_drained", done_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
